svc_rv_sram_arb: RTL and testbench

Two-requester arbiter for the shared single-port data SRAM in the RV SoC, placed between the CPU data port, the debug-bridge memory port and the SRAM macro. The CPU has priority. The debug requester has a bounded wait and can lock the port for multi-beat transfers. Read responses are routed back to whichever requester issued the read.

---
 rtl/svc_rv_sram_arb_if.sv | 60 ++++++
 rtl/svc_rv_sram_arb.sv | 160 ++++++++++++++++
 tb/tb_svc_rv_sram_arb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/svc_rv_sram_arb_if.sv
// Signal bundle between the CPU data port, the debug-bridge memory port,
// the SRAM arbiter and the single-port SRAM macro.
interface svc_rv_sram_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  // CPU requester
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [AW-1:0] cpu_req_addr;
  logic          cpu_req_wen;
  logic [DW-1:0] cpu_req_wdata;
  logic [SW-1:0] cpu_req_wstrb;
  logic          cpu_rsp_valid;
  logic [DW-1:0] cpu_rsp_data;

  // Debug requester
  logic          dbg_req_valid;
  logic          dbg_req_ready;
  logic [AW-1:0] dbg_req_addr;
  logic          dbg_req_wen;
  logic [DW-1:0] dbg_req_wdata;
  logic [SW-1:0] dbg_req_wstrb;
  logic          dbg_req_lock;
  logic          dbg_rsp_valid;
  logic [DW-1:0] dbg_rsp_data;
  logic          dbg_locked;

  // SRAM macro
  logic          mem_en;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_wen, cpu_req_wdata, cpu_req_wstrb,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
    input  dbg_req_valid, dbg_req_addr, dbg_req_wen, dbg_req_wdata, dbg_req_wstrb,
    input  dbg_req_lock,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_locked,
    output mem_en, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  // Requester / SRAM view
  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_wen, cpu_req_wdata, cpu_req_wstrb,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
    output dbg_req_valid, dbg_req_addr, dbg_req_wen, dbg_req_wdata, dbg_req_wstrb,
    output dbg_req_lock,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_locked,
    input  mem_en, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/svc_rv_sram_arb.sv
// Two-requester arbiter for the shared data SRAM: CPU priority, bounded debug
// wait, debug port lock for multi-beat transfers, and read-response routing.
module svc_rv_sram_arb #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  svc_rv_sram_arb_if.slave bus
);

  localparam int SW = DW / 8;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } mem_cmd_t;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic [1:0]    rsp_owner;   // bit0 = CPU, bit1 = debug
  logic [1:0]    owner_nxt;

  logic          cpu_gnt;
  logic          dbg_gnt;
  logic          dbg_starved;
  mem_cmd_t      cpu_cmd;
  mem_cmd_t      dbg_cmd;
  mem_cmd_t      mem_cmd;

  assign cpu_cmd = '{wen:   bus.cpu_req_wen,
                     addr:  bus.cpu_req_addr,
                     wdata: bus.cpu_req_wdata,
                     wstrb: bus.cpu_req_wstrb};

  assign dbg_cmd = '{wen:   bus.dbg_req_wen,
                     addr:  bus.dbg_req_addr,
                     wdata: bus.dbg_req_wdata,
                     wstrb: bus.dbg_req_wstrb};

  assign dbg_starved = bus.dbg_req_valid && (wait_cnt == WAIT_MAX);

  // ---------------------------------------------------------------------------
  // Grant and next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    state_nxt = state;

    unique case (state)
      ST_ARB: begin
        if (dbg_starved) begin
          dbg_gnt = 1'b1;
        end else if (bus.cpu_req_valid) begin
          cpu_gnt = 1'b1;
        end else if (bus.dbg_req_valid) begin
          dbg_gnt = 1'b1;
        end
        // Lock only takes effect on an accepted debug beat.
        if (dbg_gnt && bus.dbg_req_lock) begin
          state_nxt = ST_LOCK;
        end
      end

      ST_LOCK: begin
        // CPU stays blocked even on idle locked cycles.
        dbg_gnt = bus.dbg_req_valid;
        if (!bus.dbg_req_lock) begin
          state_nxt = ST_ARB;
        end
      end

      default: begin
        state_nxt = ST_ARB;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Debug wait counter and response owner
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_nxt = wait_cnt;
    if (!bus.dbg_req_valid || dbg_gnt) begin
      wait_nxt = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_nxt = wait_cnt + WW'(1);
    end
  end

  always_comb begin
    owner_nxt    = '0;
    owner_nxt[0] = cpu_gnt && !bus.cpu_req_wen;
    owner_nxt[1] = dbg_gnt && !bus.dbg_req_wen;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARB;
      wait_cnt  <= '0;
      rsp_owner <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      rsp_owner <= owner_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM command mux: all fields read as zero when nothing is granted
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_cmd = '0;
    if (cpu_gnt) begin
      mem_cmd = cpu_cmd;
    end else if (dbg_gnt) begin
      mem_cmd = dbg_cmd;
    end
  end

  assign bus.mem_en    = cpu_gnt | dbg_gnt;
  assign bus.mem_wen   = mem_cmd.wen;
  assign bus.mem_addr  = mem_cmd.addr;
  assign bus.mem_wdata = mem_cmd.wdata;
  assign bus.mem_wstrb = mem_cmd.wstrb;

  // ---------------------------------------------------------------------------
  // Requester-facing outputs
  // ---------------------------------------------------------------------------
  assign bus.cpu_req_ready = cpu_gnt;
  assign bus.dbg_req_ready = dbg_gnt;
  assign bus.dbg_locked    = (state == ST_LOCK);

  // Data is shared and unqualified; only rsp_valid tells the owner apart.
  assign bus.cpu_rsp_valid = rsp_owner[0];
  assign bus.dbg_rsp_valid = rsp_owner[1];
  assign bus.cpu_rsp_data  = bus.mem_rdata;
  assign bus.dbg_rsp_data  = bus.mem_rdata;

endmodule

// File: tb/tb_svc_rv_sram_arb.sv
// Directed self-checking bench for svc_rv_sram_arb with a small byte-strobed
// SRAM model behind the arbiter.
module tb_svc_rv_sram_arb;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  svc_rv_sram_arb_if #(.AW(AW), .DW(DW)) bus ();

  svc_rv_sram_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: 256 words, word index from addr[9:2], one-cycle read latency.
  logic [31:0] sram [0:255];
  logic [31:0] rdata_q;
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      sram[bd_idx] <= bd_data;
    end else if (bus.mem_en) begin
      if (bus.mem_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_wstrb[b]) sram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end else begin
        rdata_q <= sram[bus.mem_addr[9:2]];
      end
    end
  end

  assign bus.mem_rdata = rdata_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    bd_idx  = addr[9:2];
    bd_data = data;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic cpu_drive(input logic v, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata = 32'h0, input logic [3:0] wstrb = 4'hf);
    bus.cpu_req_valid = v;
    bus.cpu_req_wen   = wen;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wdata;
    bus.cpu_req_wstrb = wstrb;
  endtask

  task automatic dbg_drive(input logic v, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input logic lock);
    bus.dbg_req_valid = v;
    bus.dbg_req_wen   = wen;
    bus.dbg_req_addr  = addr;
    bus.dbg_req_wdata = wdata;
    bus.dbg_req_wstrb = wstrb;
    bus.dbg_req_lock  = lock;
  endtask

  initial begin
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    cpu_drive(0, 0, 0);
    dbg_drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;

    tick();
    preload(32'h100, 32'hAAAA_0000);
    preload(32'h104, 32'hAAAA_0004);
    preload(32'h040, 32'hDEAD_BEEF);
    preload(32'h010, 32'h1111_0010);
    preload(32'h020, 32'h2222_0020);

    // Reset values with no requests
    rst_n = 1'b1;
    settle();
    check("rst cpu_ready", bus.cpu_req_ready, 0);
    check("rst dbg_ready", bus.dbg_req_ready, 0);
    check("rst mem_en",    bus.mem_en,        0);
    check("rst mem_wen",   bus.mem_wen,       0);
    check("rst mem_addr",  bus.mem_addr,      0);
    check("rst cpu_rsp",   bus.cpu_rsp_valid, 0);
    check("rst dbg_rsp",   bus.dbg_rsp_valid, 0);
    check("rst locked",    bus.dbg_locked,    0);
    check("rst wait_cnt",  dut.wait_cnt,      0);

    // CPU-only back-to-back reads
    tick(); cpu_drive(1, 0, 32'h100); settle();
    check("rd0 cpu_ready", bus.cpu_req_ready, 1);
    check("rd0 mem_en",    bus.mem_en,        1);
    check("rd0 mem_addr",  bus.mem_addr,      32'h100);
    tick(); cpu_drive(1, 0, 32'h104); settle();
    check("rd1 cpu_ready", bus.cpu_req_ready, 1);
    check("rd0 rsp_valid", bus.cpu_rsp_valid, 1);
    check("rd0 rsp_data",  bus.cpu_rsp_data,  32'hAAAA_0000);
    check("rd0 dbg_rsp",   bus.dbg_rsp_valid, 0);
    tick(); cpu_drive(0, 0, 0); settle();
    check("rd1 rsp_valid", bus.cpu_rsp_valid, 1);
    check("rd1 rsp_data",  bus.cpu_rsp_data,  32'hAAAA_0004);
    check("rd1 dbg_rsp",   bus.dbg_rsp_valid, 0);
    tick(); settle();
    check("rd idle rsp",   bus.cpu_rsp_valid, 0);

    // Both valid continuously: CPU x4 then DBG, repeating
    tick();
    cpu_drive(1, 0, 32'h000);
    dbg_drive(1, 0, 32'h004, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("arb%0d cpu_ready", i), bus.cpu_req_ready, (i % 5) != 4);
      check($sformatf("arb%0d dbg_ready", i), bus.dbg_req_ready, (i % 5) == 4);
      check($sformatf("arb%0d wait_cnt", i),  dut.wait_cnt,      i % 5);
      tick();
    end
    cpu_drive(0, 0, 0);
    dbg_drive(0, 0, 0, 0, 0, 0);
    tick();

    // Debug partial write, then CPU read back
    dbg_drive(1, 1, 32'h040, 32'h1234_5678, 4'b0011, 0); settle();
    check("pw dbg_ready", bus.dbg_req_ready, 1);
    check("pw cpu_ready", bus.cpu_req_ready, 0);
    check("pw mem_wen",   bus.mem_wen,       1);
    check("pw mem_addr",  bus.mem_addr,      32'h40);
    check("pw mem_wstrb", bus.mem_wstrb,     4'b0011);
    check("pw mem_wdata", bus.mem_wdata,     32'h1234_5678);
    tick();
    dbg_drive(0, 0, 0, 0, 0, 0);
    cpu_drive(1, 0, 32'h040); settle();
    check("pw rd cpu_ready", bus.cpu_req_ready, 1);
    check("pw no dbg_rsp",   bus.dbg_rsp_valid, 0);
    tick(); cpu_drive(0, 0, 0); settle();
    check("pw rsp_valid", bus.cpu_rsp_valid, 1);
    check("pw rsp_data",  bus.cpu_rsp_data,  32'hDEAD_5678);
    tick();

    // Locked debug burst of 3 writes against a continuously valid CPU
    cpu_drive(1, 0, 32'h000);
    dbg_drive(1, 1, 32'h080, 32'hB0B0_0001, 4'hf, 1);
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("lk wait%0d cpu_ready", i), bus.cpu_req_ready, 1);
      check($sformatf("lk wait%0d dbg_ready", i), bus.dbg_req_ready, 0);
      tick();
    end
    settle();
    check("lk b1 dbg_ready", bus.dbg_req_ready, 1);
    check("lk b1 cpu_ready", bus.cpu_req_ready, 0);
    check("lk b1 locked",    bus.dbg_locked,    0);
    check("lk b1 mem_addr",  bus.mem_addr,      32'h80);
    tick();
    dbg_drive(1, 1, 32'h084, 32'hB0B0_0002, 4'hf, 1); settle();
    check("lk b2 locked",    bus.dbg_locked,    1);
    check("lk b2 dbg_ready", bus.dbg_req_ready, 1);
    check("lk b2 cpu_ready", bus.cpu_req_ready, 0);
    tick();
    dbg_drive(0, 0, 0, 0, 0, 1); settle();
    check("lk idle locked",    bus.dbg_locked,    1);
    check("lk idle cpu_ready", bus.cpu_req_ready, 0);
    check("lk idle mem_en",    bus.mem_en,        0);
    tick();
    dbg_drive(1, 1, 32'h088, 32'hB0B0_0003, 4'hf, 0); settle();
    check("lk b3 dbg_ready", bus.dbg_req_ready, 1);
    check("lk b3 cpu_ready", bus.cpu_req_ready, 0);
    check("lk b3 locked",    bus.dbg_locked,    1);
    tick();
    dbg_drive(0, 0, 0, 0, 0, 0); settle();
    check("lk end locked",    bus.dbg_locked,    0);
    check("lk end cpu_ready", bus.cpu_req_ready, 1);
    tick();
    cpu_drive(1, 0, 32'h084); settle();
    check("lk rb cpu_ready", bus.cpu_req_ready, 1);
    tick(); cpu_drive(0, 0, 0); settle();
    check("lk rb rsp_valid", bus.cpu_rsp_valid, 1);
    check("lk rb rsp_data",  bus.cpu_rsp_data,  32'hB0B0_0002);
    tick();

    // Alternating CPU / debug reads
    cpu_drive(1, 0, 32'h010); settle();
    check("alt c0 cpu_ready", bus.cpu_req_ready, 1);
    tick();
    cpu_drive(0, 0, 0);
    dbg_drive(1, 0, 32'h020, 0, 0, 0); settle();
    check("alt d0 dbg_ready", bus.dbg_req_ready, 1);
    check("alt c0 cpu_rsp",   bus.cpu_rsp_valid, 1);
    check("alt c0 cpu_data",  bus.cpu_rsp_data,  32'h1111_0010);
    check("alt c0 dbg_rsp",   bus.dbg_rsp_valid, 0);
    tick();
    dbg_drive(0, 0, 0, 0, 0, 0);
    cpu_drive(1, 0, 32'h010); settle();
    check("alt d0 dbg_rsp",   bus.dbg_rsp_valid, 1);
    check("alt d0 dbg_data",  bus.dbg_rsp_data,  32'h2222_0020);
    check("alt d0 cpu_rsp",   bus.cpu_rsp_valid, 0);
    tick();
    cpu_drive(0, 0, 0); settle();
    check("alt c1 cpu_rsp",   bus.cpu_rsp_valid, 1);
    check("alt c1 dbg_rsp",   bus.dbg_rsp_valid, 0);
    tick();

    // Lock request without valid in ARB is ignored
    dbg_drive(0, 0, 0, 0, 0, 1); settle();
    check("nolk mem_en", bus.mem_en, 0);
    tick();
    dbg_drive(0, 0, 0, 0, 0, 0);
    cpu_drive(1, 0, 32'h100); settle();
    check("nolk locked",    bus.dbg_locked,    0);
    check("nolk cpu_ready", bus.cpu_req_ready, 1);

    // Reset asserted while a CPU read response is due
    tick();
    cpu_drive(0, 0, 0);
    rst_n = 1'b0; settle();
    check("mrst cpu_rsp",   bus.cpu_rsp_valid, 0);
    check("mrst cpu_ready", bus.cpu_req_ready, 0);
    tick(); settle();
    check("mrst hold rsp",  bus.cpu_rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    cpu_drive(1, 0, 32'h104); settle();
    check("mrst rel rsp",    bus.cpu_rsp_valid, 0);
    check("mrst rel ready",  bus.cpu_req_ready, 1);
    check("mrst rel addr",   bus.mem_addr,      32'h104);
    check("mrst rel locked", bus.dbg_locked,    0);
    tick(); cpu_drive(0, 0, 0); settle();
    check("mrst rd rsp",  bus.cpu_rsp_valid, 1);
    check("mrst rd data", bus.cpu_rsp_data,  32'hAAAA_0004);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
